// File: rtl/display_scan_ctrl.sv
// Scan controller for a 4-digit multiplexed 7-segment display: one-hot digit
// rotation, double-buffered BCD word and active-low anodes with leading-zero blanking.
module display_scan_ctrl #(
    parameter int REFRESH_DIV   = 27000,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] bcd_in,
    input  logic        load,
    output logic [15:0] active_bcd,
    output logic [3:0]  digit_sel,
    output logic [3:0]  anodes_n,
    output logic        pending,
    output logic        frame_done,
    output logic        bcd_err
);

    localparam int            CW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] refresh_cnt;
    logic [15:0]   shadow;
    logic          tick;
    logic          wrap;
    logic          load_ok;
    logic          zero3;
    logic          zero32;
    logic          zero321;
    logic [3:0]    blank;

    assign tick    = (refresh_cnt == CNT_LAST);
    assign wrap    = tick && (digit_sel == 4'b1000);
    assign load_ok = (bcd_in[3:0]   <= 4'd9) && (bcd_in[7:4]   <= 4'd9) &&
                     (bcd_in[11:8]  <= 4'd9) && (bcd_in[15:12] <= 4'd9);

    always_ff @(posedge clk) begin
        if (rst || tick) begin
            refresh_cnt <= '0;
        end else begin
            refresh_cnt <= refresh_cnt + CW'(1);
        end
    end

    // Any non-one-hot value falls into default and is forced back to the units digit.
    always_ff @(posedge clk) begin
        if (rst) begin
            digit_sel <= 4'b0001;
        end else begin
            case (digit_sel)
                4'b0001: digit_sel <= tick ? 4'b0010 : 4'b0001;
                4'b0010: digit_sel <= tick ? 4'b0100 : 4'b0010;
                4'b0100: digit_sel <= tick ? 4'b1000 : 4'b0100;
                4'b1000: digit_sel <= tick ? 4'b0001 : 4'b1000;
                default: digit_sel <= 4'b0001;
            endcase
        end
    end

    // A load landing on the wrap still refills the shadow, so pending stays set.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow     <= '0;
            active_bcd <= '0;
            pending    <= 1'b0;
            frame_done <= 1'b0;
            bcd_err    <= 1'b0;
        end else begin
            frame_done <= wrap;
            bcd_err    <= load && !load_ok;
            if (load && load_ok) begin
                shadow <= bcd_in;
            end
            if (wrap && pending) begin
                active_bcd <= shadow;
            end
            if (load && load_ok) begin
                pending <= 1'b1;
            end else if (wrap) begin
                pending <= 1'b0;
            end
        end
    end

    assign zero3   = (active_bcd[15:12] == 4'd0);
    assign zero32  = zero3  && (active_bcd[11:8] == 4'd0);
    assign zero321 = zero32 && (active_bcd[7:4]  == 4'd0);

    always_comb begin
        blank = 4'b0000;
        if (BLANK_LEADING) begin
            blank = {zero3, zero32, zero321, 1'b0};
        end
        anodes_n = ~digit_sel | (digit_sel & blank);
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl: directed loads queue hand-computed
// expectations per cycle; a negedge monitor pops and compares them.
module tb_display_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] bcd_in = 16'h0000;

    logic [15:0] active_bcd, nb_active_bcd;
    logic [3:0]  digit_sel, nb_digit_sel;
    logic [3:0]  anodes_n, nb_anodes_n;
    logic        pending, nb_pending;
    logic        frame_done, nb_frame_done;
    logic        bcd_err, nb_bcd_err;

    display_scan_ctrl #(.REFRESH_DIV(4), .BLANK_LEADING(1'b1)) dut (
        .clk(clk), .rst(rst), .bcd_in(bcd_in), .load(load),
        .active_bcd(active_bcd), .digit_sel(digit_sel), .anodes_n(anodes_n),
        .pending(pending), .frame_done(frame_done), .bcd_err(bcd_err)
    );

    display_scan_ctrl #(.REFRESH_DIV(4), .BLANK_LEADING(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .bcd_in(bcd_in), .load(load),
        .active_bcd(nb_active_bcd), .digit_sel(nb_digit_sel), .anodes_n(nb_anodes_n),
        .pending(nb_pending), .frame_done(nb_frame_done), .bcd_err(nb_bcd_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef enum {SIG_SEL, SIG_AN, SIG_AN_NB, SIG_ACT, SIG_PEND, SIG_FD, SIG_ERR} sig_e;

    typedef struct {
        int          cyc;
        sig_e        sig;
        logic [15:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   base = 0;

    function automatic void push_exp(input int k, input sig_e s, input logic [15:0] v,
                                     input string name);
        exp_t e;
        e.cyc  = base + k;
        e.sig  = s;
        e.val  = v;
        e.name = name;
        sb.push_back(e);
    endfunction

    task automatic checkOutput(input exp_t e);
        logic [15:0] got;
        case (e.sig)
            SIG_SEL:   got = {12'h000, digit_sel};
            SIG_AN:    got = {12'h000, anodes_n};
            SIG_AN_NB: got = {12'h000, nb_anodes_n};
            SIG_ACT:   got = active_bcd;
            SIG_PEND:  got = {15'h0000, pending};
            SIG_FD:    got = {15'h0000, frame_done};
            default:   got = {15'h0000, bcd_err};
        endcase
        vectors++;
        if (got !== e.val) begin
            miscompares++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h",
                     e.name, e.cyc - base, got, e.val);
        end
    endtask

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                checkOutput(sb[i]);
                sb.delete(i);
            end else if (sb[i].cyc < cyc) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL %s at cycle %0d: never sampled, expected %h",
                         sb[i].name, sb[i].cyc - base, sb[i].val);
                sb.delete(i);
            end
        end
    end

    task automatic wait_until(input int k);
        while (cyc < base + k) @(negedge clk);
    endtask

    task automatic applyStimulus(input int k, input logic [15:0] value);
        wait_until(k);
        load   = 1'b1;
        bcd_in = value;
        @(negedge clk);
        load   = 1'b0;
    endtask

    task automatic push_all();
        logic [3:0] s;
        push_exp(0, SIG_ACT,  16'h0000, "rst active_bcd");
        push_exp(0, SIG_PEND, 16'h0000, "rst pending");
        push_exp(0, SIG_ERR,  16'h0000, "rst bcd_err");
        for (int k = 0; k < 40; k++) begin
            s = 4'b0001 << ((k / 4) % 4);
            push_exp(k, SIG_SEL, {12'h000, s}, $sformatf("scan digit_sel k%0d", k));
            push_exp(k, SIG_FD, (k == 16 || k == 32) ? 16'h0001 : 16'h0000,
                     $sformatf("scan frame_done k%0d", k));
            if (k % 4 == 0) begin
                push_exp(k, SIG_AN, (s == 4'b0001) ? 16'h000E : 16'h000F,
                         $sformatf("zero anodes_n k%0d", k));
                push_exp(k, SIG_AN_NB, {12'h000, ~s}, $sformatf("zero nb anodes_n k%0d", k));
            end
        end
        // single valid load, transfer at wrap 48
        push_exp(37, SIG_PEND, 16'h0000, "load0042 pending before");
        push_exp(38, SIG_PEND, 16'h0001, "load0042 pending after");
        push_exp(47, SIG_ACT,  16'h0000, "load0042 active held");
        push_exp(48, SIG_ACT,  16'h0042, "load0042 active wrap");
        push_exp(48, SIG_PEND, 16'h0000, "load0042 pending cleared");
        push_exp(48, SIG_FD,   16'h0001, "load0042 frame_done");
        push_exp(49, SIG_AN,   16'h000E, "0042 anodes units");
        push_exp(53, SIG_AN,   16'h000D, "0042 anodes tens");
        push_exp(57, SIG_AN,   16'h000F, "0042 anodes hundreds");
        push_exp(61, SIG_AN,   16'h000F, "0042 anodes thousands");
        push_exp(53, SIG_AN_NB, 16'h000D, "0042 nb anodes tens");
        // rejected load
        push_exp(50, SIG_ERR,  16'h0000, "bad load err before");
        push_exp(51, SIG_ERR,  16'h0001, "bad load err pulse");
        push_exp(52, SIG_ERR,  16'h0000, "bad load err cleared");
        push_exp(51, SIG_PEND, 16'h0000, "bad load pending");
        push_exp(64, SIG_ACT,  16'h0042, "bad load active kept");
        push_exp(64, SIG_PEND, 16'h0000, "bad load pending at wrap");
        push_exp(64, SIG_FD,   16'h0001, "frame_done 64");
        // load coinciding with the wrap tick
        push_exp(67, SIG_PEND, 16'h0001, "load0005 pending");
        push_exp(79, SIG_ACT,  16'h0042, "coincide active before");
        push_exp(80, SIG_ACT,  16'h0005, "coincide active old shadow");
        push_exp(80, SIG_PEND, 16'h0001, "coincide pending kept");
        push_exp(80, SIG_FD,   16'h0001, "frame_done 80");
        push_exp(81, SIG_FD,   16'h0000, "frame_done 81");
        push_exp(95, SIG_ACT,  16'h0005, "coincide active held");
        push_exp(96, SIG_ACT,  16'h1234, "coincide active new");
        push_exp(96, SIG_PEND, 16'h0000, "coincide pending cleared");
        push_exp(96,  SIG_AN,  16'h000E, "1234 anodes units");
        push_exp(100, SIG_AN,  16'h000D, "1234 anodes tens");
        push_exp(104, SIG_AN,  16'h000B, "1234 anodes hundreds");
        push_exp(108, SIG_AN,  16'h0007, "1234 anodes thousands");
        // back-to-back loads, unblanked instance
        push_exp(99,  SIG_PEND,  16'h0001, "b2b pending");
        push_exp(111, SIG_ACT,   16'h1234, "b2b active held");
        push_exp(112, SIG_ACT,   16'h0007, "b2b last load wins");
        push_exp(112, SIG_AN_NB, 16'h000E, "0007 nb anodes units");
        push_exp(116, SIG_AN_NB, 16'h000D, "0007 nb anodes tens");
        push_exp(120, SIG_AN_NB, 16'h000B, "0007 nb anodes hundreds");
        push_exp(124, SIG_AN_NB, 16'h0007, "0007 nb anodes thousands");
        push_exp(116, SIG_AN,    16'h000F, "0007 anodes tens blanked");
        // mid-frame reset with a load in the same cycle
        push_exp(128, SIG_ACT,  16'h0999, "pre-reset active");
        push_exp(131, SIG_PEND, 16'h0001, "pre-reset pending");
        push_exp(136, SIG_SEL,  16'h0004, "pre-reset digit_sel");
        push_exp(136, SIG_ACT,  16'h0999, "pre-reset active held");
        push_exp(138, SIG_SEL,  16'h0001, "mid rst digit_sel");
        push_exp(138, SIG_AN,   16'h000E, "mid rst anodes_n");
        push_exp(138, SIG_ACT,  16'h0000, "mid rst active_bcd");
        push_exp(138, SIG_PEND, 16'h0000, "mid rst pending");
        push_exp(138, SIG_FD,   16'h0000, "mid rst frame_done");
        push_exp(138, SIG_ERR,  16'h0000, "mid rst bcd_err");
        push_exp(139, SIG_PEND, 16'h0000, "mid rst load discarded");
        push_exp(141, SIG_SEL,  16'h0001, "mid rst counter hold");
        push_exp(142, SIG_SEL,  16'h0002, "mid rst counter restart");
        push_exp(154, SIG_FD,   16'h0001, "post rst frame_done");
        push_exp(154, SIG_ACT,  16'h0000, "post rst active");
    endtask

    initial begin
        @(negedge clk);
        base = cyc + 1;
        push_all();
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(37, 16'h0042);
        applyStimulus(50, 16'h12A4);
        applyStimulus(66, 16'h0005);
        applyStimulus(79, 16'h1234);
        applyStimulus(98, 16'h0006);
        applyStimulus(99, 16'h0007);
        applyStimulus(114, 16'h0999);
        applyStimulus(130, 16'h0123);
        wait_until(137);
        rst    = 1'b1;
        load   = 1'b1;
        bcd_in = 16'h0456;
        @(negedge clk);
        rst  = 1'b0;
        load = 1'b0;
        wait_until(165);
        if (sb.size() != 0) begin
            miscompares += sb.size();
            vectors += sb.size();
            $display("[TB] FAIL scoreboard drain: got %0d left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
